// File: rtl/cam_pkg.sv
// Shared types and table encoding for the OV camera boot-time register sequencer.
package cam_pkg;

    typedef enum logic [3:0] {
        ST_BOOT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_FWAIT  = 4'd2,
        ST_DECODE = 4'd3,
        ST_WAIT   = 4'd4,
        ST_GAP    = 4'd5,
        ST_DLY    = 4'd6,
        ST_DONE   = 4'd7,
        ST_FAIL   = 4'd8
    } seq_state_e;

    typedef enum logic [1:0] {
        ENT_WRITE = 2'd0,
        ENT_DELAY = 2'd1,
        ENT_END   = 2'd2
    } entry_kind_e;

    localparam logic [15:0] TBL_END     = 16'hFFFF;
    localparam logic [7:0]  TBL_DLY_TAG = 8'hFE;
    localparam logic [7:0]  DEF_DEV_ID  = 8'h42;

    function automatic entry_kind_e entry_kind(input logic [15:0] ent);
        entry_kind_e k;
        if (ent == TBL_END)
            k = ENT_END;
        else if (ent[15:8] == TBL_DLY_TAG)
            k = ENT_DELAY;
        else
            k = ENT_WRITE;
        return k;
    endfunction

endpackage

// File: rtl/ov_reg_table.sv
// Synchronous register-table ROM for the OV sensor: {reg, val} per entry, data valid
// one cycle after the address changes. Sits beside the sequencer at the camera top level.
module ov_reg_table
    import cam_pkg::*;
#(
    parameter int TBL_AW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TBL_AW-1:0] addr_i,
    output logic [15:0]       data_o
);

    logic [15:0] rom_d;

    always_comb begin
        case (32'(addr_i))
            0:       rom_d = 16'h1280;   // soft reset of all sensor registers
            1:       rom_d = 16'hFE0A;   // let the reset settle: 10 ticks
            2:       rom_d = 16'h1204;
            3:       rom_d = 16'h1101;
            4:       rom_d = 16'h0C00;
            5:       rom_d = 16'h3E00;
            6:       rom_d = 16'h8C00;
            7:       rom_d = 16'h0400;
            8:       rom_d = 16'h40D0;
            9:       rom_d = 16'h3A04;
            10:      rom_d = 16'h1438;
            11:      rom_d = 16'h4FB3;
            12:      rom_d = 16'h50B3;
            13:      rom_d = 16'h5100;
            14:      rom_d = 16'h523D;
            15:      rom_d = 16'h53A7;
            16:      rom_d = 16'h54E4;
            17:      rom_d = 16'h589E;
            18:      rom_d = 16'h3DC0;
            19:      rom_d = 16'h1714;
            20:      rom_d = 16'h1802;
            21:      rom_d = 16'h3280;
            22:      rom_d = 16'h1903;
            23:      rom_d = 16'h1A7B;
            24:      rom_d = 16'h030A;
            default: rom_d = TBL_END;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            data_o <= TBL_END;
        else
            data_o <= rom_d;
    end

endmodule

// File: rtl/ov_reg_sequencer.sv
// Boot-time configuration sequencer: walks the register table, issues one SCCB write per
// entry via req/done, retries NACKs after a gap, honours delay entries, then flags work_done.
module ov_reg_sequencer
    import cam_pkg::*;
#(
    parameter logic [7:0]  DEV_ID    = DEF_DEV_ID,
    parameter int          TBL_AW    = 8,
    parameter logic [23:0] BOOT_WAIT = 24'd250000,
    parameter logic [15:0] DLY_UNIT  = 16'd25000,
    parameter int          MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [15:0]       tbl_data,
    output logic              sccb_req,
    output logic [7:0]        sccb_id,
    output logic [7:0]        sccb_reg,
    output logic [7:0]        sccb_val,
    input  logic              sccb_done,
    input  logic              sccb_nack,
    output logic              work_done,
    output logic              error,
    output logic [23:0]       debug_out
);

    seq_state_e        state_q, state_d;
    logic [TBL_AW-1:0] addr_q, addr_d;
    logic [3:0]        retry_q, retry_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [31:0]       tgt_q, tgt_d;
    logic [7:0]        reg_q, reg_d;
    logic [7:0]        val_q, val_d;

    entry_kind_e       kind;
    logic [31:0]       cnt_inc;
    logic              boot_exp, gap_exp, dly_exp;
    logic              last_addr;
    logic [31:0]       dly_len;
    seq_state_e        adv_state;
    logic [TBL_AW-1:0] adv_addr;

    assign kind      = entry_kind(tbl_data);
    assign cnt_inc   = cnt_q + 32'd1;
    assign boot_exp  = cnt_inc >= {8'd0, BOOT_WAIT};
    assign gap_exp   = cnt_inc >= {16'd0, DLY_UNIT};
    assign dly_exp   = cnt_inc >= tgt_q;
    assign last_addr = &addr_q;
    assign dly_len   = 32'(tbl_data[7:0]) * 32'(DLY_UNIT);

    // Completing the last table slot acts as an implicit END.
    assign adv_state = last_addr ? ST_DONE : ST_FETCH;
    assign adv_addr  = last_addr ? addr_q : addr_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
            addr_q  <= '0;
            retry_q <= '0;
            cnt_q   <= '0;
            tgt_q   <= '0;
            reg_q   <= '0;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            retry_q <= retry_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            reg_q   <= reg_d;
            val_q   <= val_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        retry_d = retry_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        reg_d   = reg_q;
        val_d   = val_q;
        case (state_q)
            ST_BOOT: begin
                if (boot_exp) begin
                    state_d = ST_FETCH;
                    addr_d  = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_FETCH:  state_d = ST_FWAIT;
            ST_FWAIT:  state_d = ST_DECODE;
            ST_DECODE: begin
                case (kind)
                    ENT_END: state_d = ST_DONE;
                    ENT_DELAY: begin
                        if (tbl_data[7:0] == 8'd0) begin
                            state_d = adv_state;
                            addr_d  = adv_addr;
                        end else begin
                            state_d = ST_DLY;
                            cnt_d   = '0;
                            tgt_d   = dly_len;
                        end
                    end
                    default: begin
                        state_d = ST_WAIT;
                        reg_d   = tbl_data[15:8];
                        val_d   = tbl_data[7:0];
                    end
                endcase
            end
            ST_WAIT: begin
                if (sccb_done) begin
                    if (!sccb_nack) begin
                        state_d = adv_state;
                        addr_d  = adv_addr;
                        retry_d = '0;
                    end else if (retry_q < 4'(MAX_RETRY)) begin
                        state_d = ST_GAP;
                        retry_d = retry_q + 4'd1;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
            end
            ST_GAP: begin
                if (gap_exp)
                    state_d = ST_WAIT;
                else
                    cnt_d = cnt_inc;
            end
            ST_DLY: begin
                if (dly_exp) begin
                    state_d = adv_state;
                    addr_d  = adv_addr;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DONE, ST_FAIL: begin
                if (start) begin
                    state_d = ST_BOOT;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // Writes are issued straight out of DECODE so done->next req is FETCH, FWAIT, DECODE.
    always_comb begin
        sccb_req  = 1'b0;
        sccb_reg  = reg_q;
        sccb_val  = val_q;
        work_done = 1'b0;
        error     = 1'b0;
        case (state_q)
            ST_DECODE: begin
                if (kind == ENT_WRITE) begin
                    sccb_req = 1'b1;
                    sccb_reg = tbl_data[15:8];
                    sccb_val = tbl_data[7:0];
                end else if (kind == ENT_END) begin
                    work_done = 1'b1;
                end
            end
            ST_GAP:  sccb_req  = gap_exp;
            ST_DONE: work_done = 1'b1;
            ST_FAIL: error     = 1'b1;
            default: ;
        endcase
    end

    assign sccb_id   = DEV_ID;
    assign tbl_addr  = addr_q;
    assign debug_out = {state_q, retry_q, 8'(addr_q), sccb_reg};

endmodule
